// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I fetch/decode control slice: opcodes,
// funct fields, ALU operation encodings and the controller state type.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // ALU operation select, shared with the ALU in the datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    TRAP   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder for the supported R-type ALU ops and
// BEQ/BNE; anything else is flagged illegal.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [3:0]  o_alu_control,
  output logic        o_is_rtype,
  output logic        o_is_branch,
  output logic        o_is_bne,
  output logic        o_illegal,
  output logic [31:0] o_imm_b
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = i_ir[6:0];
  assign w_funct3 = i_ir[14:12];
  assign w_funct7 = i_ir[31:25];

  assign o_rs1 = i_ir[19:15];
  assign o_rs2 = i_ir[24:20];
  assign o_rd  = i_ir[11:7];

  assign o_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};

  // Classify the instruction and pick the ALU op; illegal unless a row matches
  always_comb begin
    o_alu_control = ALU_ADD;
    o_is_rtype    = 1'b0;
    o_is_branch   = 1'b0;
    o_is_bne      = 1'b0;
    o_illegal     = 1'b1;
    case (w_opcode)
      OP_RTYPE: begin
        o_is_rtype = 1'b1;
        o_illegal  = 1'b0;
        case ({w_funct7, w_funct3})
          {F7_BASE, F3_ADD_SUB}: o_alu_control = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: o_alu_control = ALU_SUB;
          {F7_BASE, F3_SLL}:     o_alu_control = ALU_SLL;
          {F7_BASE, F3_SLT}:     o_alu_control = ALU_SLT;
          {F7_BASE, F3_XOR}:     o_alu_control = ALU_XOR;
          {F7_BASE, F3_SRL}:     o_alu_control = ALU_SRL;
          {F7_BASE, F3_OR}:      o_alu_control = ALU_OR;
          {F7_BASE, F3_AND}:     o_alu_control = ALU_AND;
          default: begin
            o_is_rtype = 1'b0;
            o_illegal  = 1'b1;
          end
        endcase
      end
      OP_BRANCH: begin
        if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE) begin
          o_is_branch   = 1'b1;
          o_is_bne      = (w_funct3 == F3_BNE);
          o_alu_control = ALU_SUB;
          o_illegal     = 1'b0;
        end
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode controller: owns the PC, runs the req/valid
// instruction fetch, decodes into datapath controls and resolves branches.
module fetch_decode_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_run,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_valid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_zero_flag,
  output logic [4:0]      o_read_reg1,
  output logic [4:0]      o_read_reg2,
  output logic [4:0]      o_write_reg,
  output logic [3:0]      o_alu_control,
  output logic            o_write_on_register,
  output logic [XLEN-1:0] o_pc,
  output logic            o_instr_retired,
  output logic            o_illegal_instr
);

  ctrl_state_e     r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_imem_req;
  logic [4:0]      r_read_reg1;
  logic [4:0]      r_read_reg2;
  logic [4:0]      r_write_reg;
  logic [3:0]      r_alu_control;
  logic            r_wr_en;
  logic            r_retired;
  logic            r_illegal;

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [3:0]      w_alu_control;
  logic            w_is_rtype;
  logic            w_is_branch;
  logic            w_is_bne;
  logic            w_illegal;
  logic [31:0]     w_imm_b;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_branch_target;
  logic            w_taken;
  logic            w_misaligned;

  instr_decoder u_decoder (
    .i_ir          (r_ir),
    .o_rs1         (w_rs1),
    .o_rs2         (w_rs2),
    .o_rd          (w_rd),
    .o_alu_control (w_alu_control),
    .o_is_rtype    (w_is_rtype),
    .o_is_branch   (w_is_branch),
    .o_is_bne      (w_is_bne),
    .o_illegal     (w_illegal),
    .o_imm_b       (w_imm_b)
  );

  assign w_pc_plus4      = r_pc + XLEN'(4);
  assign w_branch_target = r_pc + w_imm_b;
  assign w_taken         = w_is_branch & (w_is_bne ? ~i_zero_flag : i_zero_flag);
  assign w_misaligned    = (w_branch_target[1:0] != 2'b00);

  assign o_imem_req          = r_imem_req;
  assign o_imem_addr         = r_pc;
  assign o_pc                = r_pc;
  assign o_read_reg1         = r_read_reg1;
  assign o_read_reg2         = r_read_reg2;
  assign o_write_reg         = r_write_reg;
  assign o_alu_control       = r_alu_control;
  assign o_write_on_register = r_wr_en;
  assign o_instr_retired     = r_retired;
  assign o_illegal_instr     = r_illegal;

  // Controller FSM; the next request is launched straight out of EXEC so a
  // zero-wait instruction takes three cycles, and retire lands with the new pc
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_imem_req    <= 1'b0;
      r_read_reg1   <= '0;
      r_read_reg2   <= '0;
      r_write_reg   <= '0;
      r_alu_control <= ALU_ADD;
      r_wr_en       <= 1'b0;
      r_retired     <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_retired <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!r_imem_req) begin
            if (i_run) begin
              r_imem_req <= 1'b1;
            end
          end else if (i_imem_valid) begin
            r_ir       <= i_imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= DECODE;
          end
        end
        DECODE: begin
          r_read_reg1   <= w_rs1;
          r_read_reg2   <= w_rs2;
          r_write_reg   <= w_rd;
          r_alu_control <= w_alu_control;
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= TRAP;
          end else begin
            r_wr_en <= w_is_rtype && (w_rd != 5'd0);
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_wr_en <= 1'b0;
          if (w_taken && w_misaligned) begin
            r_illegal <= 1'b1;
            r_state   <= TRAP;
          end else begin
            r_pc       <= w_taken ? w_branch_target : w_pc_plus4;
            r_retired  <= 1'b1;
            r_imem_req <= i_run;
            r_state    <= FETCH;
          end
        end
        TRAP: begin
          r_imem_req <= 1'b0;
          r_wr_en    <= 1'b0;
        end
        default: begin
          r_state <= TRAP;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode control unit directly upstream of `datapath`.
- Fetches 32-bit RV32I instructions over a simple req/valid instruction-memory port and decodes them.
- Drives `datapath` register addresses, `alu_control` and `write_on_register`; consumes `zero_flag` to resolve BEQ/BNE.
- Owns the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, instruction/PC width; only 32 supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 at posedge clears state)
- run  input  1  permits a new fetch to start
- imem_req  output  1  fetch request
- imem_addr  output  XLEN  fetch address (= pc)
- imem_valid  input  1  imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- zero_flag  input  1  from datapath ALU
- read_reg1  output  5  rs1 to datapath
- read_reg2  output  5  rs2 to datapath
- write_reg  output  5  rd to datapath
- alu_control  output  4  ALU operation select
- write_on_register  output  1  register-file write enable
- pc  output  XLEN  current PC
- instr_retired  output  1  one-cycle pulse per completed legal instruction
- illegal_instr  output  1  sticky trap flag

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0, read_reg1/read_reg2/write_reg=0, alu_control=ADD, write_on_register=0, instr_retired=0, illegal_instr=0, IR=0.
- Reset has priority over every other event in every state; mid-fetch, imem_req drops the next cycle and a late imem_valid is ignored.
- FETCH:
  - If run=1, assert imem_req with imem_addr=pc; hold both stable until imem_valid=1.
  - imem_valid may arrive in the same cycle as req.
  - On the valid edge, latch IR=imem_rdata and go to DECODE; imem_req drops.
  - run=0: stay in FETCH with imem_req=0. run is only examined before a request starts; once issued, the instruction completes.
  - imem_valid while imem_req=0 is ignored.
- DECODE (1 cycle):
  - Register read_reg1=IR[19:15], read_reg2=IR[24:20], write_reg=IR[11:7] and alu_control.
  - Unsupported encoding: set illegal_instr, go to TRAP.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - Address and alu_control outputs held stable.
  - R-type: write_on_register=1 for exactly this cycle, except rd=0, which forces 0.
  - Branch: write_on_register=0; ALU op SUB; sample zero_flag at the end of EXEC.
  - Taken = (BEQ and zero_flag) or (BNE and !zero_flag).
  - pc <= taken ? pc+immB : pc+4, with mod-2^32 wrap; instr_retired=1 this cycle; next state FETCH.
  - Taken target with target[1:0]!=0: no pc update, no retire, illegal_instr=1, go to TRAP.
- TRAP: all enables 0, imem_req=0, pc frozen; exit only via reset.
- Decode table (opcode 0110011, funct7/funct3):
  - ADD 0000000/000
  - SUB 0100000/000
  - SLL 0000000/001
  - SLT 0000000/010
  - XOR 0000000/100
  - SRL 0000000/101
  - OR 0000000/110
  - AND 0000000/111
  - Branch: opcode 1100011, funct3 000 BEQ, 001 BNE.
  - Everything else is illegal.
- ALU encodings: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SLT 0111.
- immB = sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}).
- Throughput: 3 cycles per instruction at zero memory wait, plus 1 cycle per wait cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_BRANCH)
  - funct3/funct7 constants
  - ALU_* 4-bit encodings, shared with the ALU
  - state enum FETCH/DECODE/EXEC/TRAP
- One combinational sub-module, instr_decoder: IR in → rs1/rs2/rd, alu_control, is_rtype, is_branch, is_bne, illegal, immB out.
- The FSM, PC and handshake stay in fetch_decode_ctrl.

Test Plan:
- Reset held low 2 cycles, then released with run=1 → all outputs at reset values during reset; imem_req=1, imem_addr=0 in the first cycle after release.
- run=1, instruction 0x002081B3 (add x3,x1,x2) returned with 0 wait → DECODE gives read_reg1=1, read_reg2=2, write_reg=3, alu_control=0010; EXEC gives write_on_register=1 for one cycle and instr_retired=1; pc goes 0→4.
- Instruction 0x40208233 (sub x4,x1,x2) with imem_valid delayed 3 cycles → imem_req/imem_addr stable for 4 cycles; alu_control=0110, write_reg=4.
- pc=8, instruction 0x00208463 (beq x1,x2,+8): zero_flag=1 → pc=16, write_on_register stays 0. Repeat with zero_flag=0 → pc=12.
- Instruction 0x00000013 (ADDI, unsupported) → illegal_instr=1 after DECODE; no write; imem_req stays 0 indefinitely; reset clears the flag.
- Reset asserted during EXEC of an ADD → write_on_register=0 on the next edge and pc=RESET_PC; no retire pulse.
